// File: rtl/iir_biquad_cascade_pkg.sv
// rtl/iir_biquad_cascade_pkg.sv - shared types and fixed-point helpers for the biquad cascade
// Holds the coefficient index and FSM state enums, the accumulator width
// function and the round-half-up / saturate helper used by fxp_round_sat.
package iir_pkg;

    typedef enum logic [2:0] {
        COEF_B0 = 3'd0,
        COEF_B1 = 3'd1,
        COEF_B2 = 3'd2,
        COEF_A1 = 3'd3,
        COEF_A2 = 3'd4
    } coef_idx_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_CONV,
        ST_OUT
    } state_e;

    // Five exact products of INTER x COEF bits summed without wrap need 3 guard bits.
    function automatic int acc_width(input int len_inter, input int len_coef);
        return len_inter + len_coef + 3;
    endfunction

    // drop > 0: round half up and shift right; drop < 0: shift left (exact).
    // Returns {value, sat} with value saturated to out_len signed bits.
    function automatic logic [64:0] round_sat(input logic signed [63:0] v,
                                              input int drop, input int out_len);
        logic signed [63:0] r;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        logic               sat;
        r = v;
        if (drop > 0) begin
            r = (v + (64'sd1 <<< (drop - 1))) >>> drop;
        end else if (drop < 0) begin
            r = v <<< (-drop);
        end
        max_v = (64'sd1 <<< (out_len - 1)) - 64'sd1;
        min_v = -max_v - 64'sd1;
        sat   = 1'b0;
        if (r > max_v) begin
            r   = max_v;
            sat = 1'b1;
        end else if (r < min_v) begin
            r   = min_v;
            sat = 1'b1;
        end
        return {r, sat};
    endfunction

endpackage

// File: rtl/iir_biquad_cascade_if.sv
// rtl/iir_biquad_cascade_if.sv - sample stream handshake bundle for the biquad cascade
// in_valid/in_ready/x carry samples in, out_valid/out_ready/y carry results out.
// master = sample source/sink side, slave = filter side.
interface iir_biquad_cascade_if #(
    parameter int WORD_LEN_IN  = 16,
    parameter int WORD_LEN_OUT = 16
);
    logic                           in_valid;
    logic                           in_ready;
    logic signed [WORD_LEN_IN-1:0]  x;
    logic                           out_valid;
    logic                           out_ready;
    logic signed [WORD_LEN_OUT-1:0] y;

    modport master (output in_valid, x, out_ready, input in_ready, out_valid, y);
    modport slave  (input in_valid, x, out_ready, output in_ready, out_valid, y);
endinterface

// File: rtl/iir_biquad_cascade_fxp_round_sat.sv
// rtl/iir_biquad_cascade_fxp_round_sat.sv - fixed-point requantizer (round half up, saturate)
// din: IN_LEN signed; dout: OUT_LEN signed; sat: result was clipped.
// DROP > 0 removes DROP fraction bits with rounding, DROP < 0 adds fraction bits.
module fxp_round_sat
    import iir_pkg::*;
#(
    parameter int IN_LEN  = 16,
    parameter int OUT_LEN = 16,
    parameter int DROP    = 0
) (
    input  logic signed [IN_LEN-1:0]  din,
    output logic signed [OUT_LEN-1:0] dout,
    output logic                      sat
);
    logic signed [63:0] din_ext;
    logic [64:0]        res;
    logic               unused_hi;

    assign din_ext   = {{(64 - IN_LEN){din[IN_LEN-1]}}, din};
    assign res       = round_sat(din_ext, DROP, OUT_LEN);
    assign dout      = res[OUT_LEN:1];
    assign sat       = res[0];
    // Upper bits are only sign copies of the saturated value.
    assign unused_hi = ^res[64:OUT_LEN+1];
endmodule

// File: rtl/iir_biquad_cascade.sv
// rtl/iir_biquad_cascade.sv - N_SECT cascaded DF-I biquads on one shared MAC
// Ports: clk, rst_n (async, active low); s_if sample stream (slave);
// coef_we/coef_sect/coef_idx/coef_wdata coefficient write (IDLE only);
// clear_state zeroes history and sat_flag (IDLE only); sat_flag sticky saturation.
module iir_biquad_cascade
    import iir_pkg::*;
#(
    parameter int WORD_LEN_IN     = 16,
    parameter int WORD_FRAC_IN    = 15,
    parameter int WORD_LEN_OUT    = 16,
    parameter int WORD_FRAC_OUT   = 15,
    parameter int WORD_LEN_COEF   = 18,
    parameter int WORD_FRAC_COEF  = 15,
    parameter int WORD_LEN_INTER  = 24,
    parameter int WORD_FRAC_INTER = 20,
    parameter int N_SECT          = 2,
    localparam int SECT_W = (N_SECT > 1) ? $clog2(N_SECT) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    iir_biquad_cascade_if.slave             s_if,
    input  logic                            coef_we,
    input  logic [SECT_W-1:0]               coef_sect,
    input  logic [2:0]                      coef_idx,
    input  logic signed [WORD_LEN_COEF-1:0] coef_wdata,
    input  logic                            clear_state,
    output logic                            sat_flag
);
    localparam int ACC_W = acc_width(WORD_LEN_INTER, WORD_LEN_COEF);
    localparam logic [SECT_W-1:0] LAST_SECT = SECT_W'(N_SECT - 1);

    typedef logic signed [WORD_LEN_INTER-1:0] inter_t;
    typedef logic signed [WORD_LEN_COEF-1:0]  coef_t;

    state_e                         state_q, state_d;
    logic [SECT_W-1:0]              sect_q, sect_d;
    logic [2:0]                     tap_q, tap_d;
    inter_t                         u_q, u_d;
    logic signed [ACC_W-1:0]        acc_q, acc_d;
    logic signed [WORD_LEN_OUT-1:0] y_q, y_d;
    logic                           sat_q, sat_d;
    coef_t                          coef_q [N_SECT][5];
    coef_t                          coef_d [N_SECT][5];
    inter_t                         u1_q [N_SECT], u1_d [N_SECT];
    inter_t                         u2_q [N_SECT], u2_d [N_SECT];
    inter_t                         w1_q [N_SECT], w1_d [N_SECT];
    inter_t                         w2_q [N_SECT], w2_d [N_SECT];

    inter_t                         x_inter, w_sect;
    logic signed [WORD_LEN_OUT-1:0] y_conv;
    logic                           x_sat, w_sat, y_sat;
    inter_t                         mul_a;
    coef_t                          mul_b;
    logic signed [ACC_W-1:0]        prod, acc_base;

    fxp_round_sat #(.IN_LEN(WORD_LEN_IN), .OUT_LEN(WORD_LEN_INTER),
                    .DROP(WORD_FRAC_IN - WORD_FRAC_INTER))
        u_in_conv (.din(s_if.x), .dout(x_inter), .sat(x_sat));

    fxp_round_sat #(.IN_LEN(ACC_W), .OUT_LEN(WORD_LEN_INTER), .DROP(WORD_FRAC_COEF))
        u_sect_conv (.din(acc_q), .dout(w_sect), .sat(w_sat));

    fxp_round_sat #(.IN_LEN(WORD_LEN_INTER), .OUT_LEN(WORD_LEN_OUT),
                    .DROP(WORD_FRAC_INTER - WORD_FRAC_OUT))
        u_out_conv (.din(u_q), .dout(y_conv), .sat(y_sat));

    // Shared MAC operand selection; feedback taps (3, 4) are subtracted.
    always_comb begin
        mul_a = u_q;
        mul_b = coef_q[sect_q][COEF_B0];
        case (tap_q)
            3'd1:    begin mul_a = u1_q[sect_q]; mul_b = coef_q[sect_q][COEF_B1]; end
            3'd2:    begin mul_a = u2_q[sect_q]; mul_b = coef_q[sect_q][COEF_B2]; end
            3'd3:    begin mul_a = w1_q[sect_q]; mul_b = coef_q[sect_q][COEF_A1]; end
            3'd4:    begin mul_a = w2_q[sect_q]; mul_b = coef_q[sect_q][COEF_A2]; end
            default: begin mul_a = u_q;          mul_b = coef_q[sect_q][COEF_B0]; end
        endcase
        prod     = ACC_W'(mul_a) * ACC_W'(mul_b);
        acc_base = (tap_q == 3'd0) ? '0 : acc_q;
    end

    always_comb begin
        state_d = state_q;
        sect_d  = sect_q;
        tap_d   = tap_q;
        u_d     = u_q;
        acc_d   = acc_q;
        y_d     = y_q;
        sat_d   = sat_q;
        coef_d  = coef_q;
        u1_d    = u1_q;
        u2_d    = u2_q;
        w1_d    = w1_q;
        w2_d    = w2_q;
        case (state_q)
            ST_IDLE: begin
                if (coef_we && (coef_idx <= COEF_A2) && (32'(coef_sect) < N_SECT)) begin
                    coef_d[coef_sect][coef_idx] = coef_wdata;
                end
                if (clear_state) begin
                    for (int s = 0; s < N_SECT; s++) begin
                        u1_d[s] = '0;
                        u2_d[s] = '0;
                        w1_d[s] = '0;
                        w2_d[s] = '0;
                    end
                    sat_d = 1'b0;
                end
                if (s_if.in_valid) begin
                    u_d     = x_inter;
                    sat_d   = sat_d | x_sat;
                    sect_d  = '0;
                    tap_d   = '0;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                if (tap_q != 3'd5) begin
                    acc_d = (tap_q >= 3'd3) ? (acc_base - prod) : (acc_base + prod);
                    tap_d = tap_q + 3'd1;
                end else begin
                    u2_d[sect_q] = u1_q[sect_q];
                    u1_d[sect_q] = u_q;
                    w2_d[sect_q] = w1_q[sect_q];
                    w1_d[sect_q] = w_sect;
                    u_d          = w_sect;
                    sat_d        = sat_q | w_sat;
                    tap_d        = '0;
                    if (sect_q == LAST_SECT) begin
                        state_d = ST_CONV;
                    end else begin
                        sect_d = sect_q + 1'b1;
                    end
                end
            end
            ST_CONV: begin
                y_d     = y_conv;
                sat_d   = sat_q | y_sat;
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (s_if.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sect_q  <= '0;
            tap_q   <= '0;
            u_q     <= '0;
            acc_q   <= '0;
            y_q     <= '0;
            sat_q   <= 1'b0;
            for (int s = 0; s < N_SECT; s++) begin
                u1_q[s] <= '0;
                u2_q[s] <= '0;
                w1_q[s] <= '0;
                w2_q[s] <= '0;
                for (int c = 0; c < 5; c++) begin
                    coef_q[s][c] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            sect_q  <= sect_d;
            tap_q   <= tap_d;
            u_q     <= u_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
            sat_q   <= sat_d;
            coef_q  <= coef_d;
            u1_q    <= u1_d;
            u2_q    <= u2_d;
            w1_q    <= w1_d;
            w2_q    <= w2_d;
        end
    end

    assign s_if.in_ready  = (state_q == ST_IDLE);
    assign s_if.out_valid = (state_q == ST_OUT);
    assign s_if.y         = y_q;
    assign sat_flag       = sat_q;
endmodule

// File: tb/tb_iir_biquad_cascade.sv
// tb/tb_iir_biquad_cascade.sv - directed self-checking bench for iir_biquad_cascade
module tb_iir_biquad_cascade;
    logic               clk = 1'b0;
    logic               rst_n;
    logic               coef_we;
    logic [0:0]         coef_sect;
    logic [2:0]         coef_idx;
    logic signed [17:0] coef_wdata;
    logic               clear_state;
    logic               sat_flag;
    int                 checks = 0;
    int                 errors = 0;

    iir_biquad_cascade_if #(.WORD_LEN_IN(16), .WORD_LEN_OUT(16)) bus ();

    iir_biquad_cascade dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_if       (bus.slave),
        .coef_we    (coef_we),
        .coef_sect  (coef_sect),
        .coef_idx   (coef_idx),
        .coef_wdata (coef_wdata),
        .clear_state(clear_state),
        .sat_flag   (sat_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wcoef(input int s, input int i, input int v);
        coef_we    = 1'b1;
        coef_sect  = 1'(s);
        coef_idx   = 3'(i);
        coef_wdata = 18'(v);
        tick();
        coef_we    = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_state = 1'b1;
        tick();
        clear_state = 1'b0;
    endtask

    // Returns one time unit after the acceptance edge.
    task automatic send(input logic [15:0] xv);
        int n = 0;
        bus.x        = xv;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 100) begin
            tick();
            n++;
        end
        check("send_ready", {31'b0, bus.in_ready}, 32'd1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic recv(output logic [15:0] yv, output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 200) begin
            tick();
            lat++;
        end
        check("recv_valid", {31'b0, bus.out_valid}, 32'd1);
        yv            = bus.y;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        logic [15:0] yv;
        logic [15:0] ys;
        int          lat;
        logic [15:0] pole_exp [4];

        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.x        = '0;
        bus.out_ready = 1'b0;
        coef_we      = 1'b0;
        coef_sect    = '0;
        coef_idx     = '0;
        coef_wdata   = '0;
        clear_state  = 1'b0;
        #2;
        check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_y", {16'b0, bus.y}, 32'd0);
        check("rst_sat", {31'b0, sat_flag}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Pass-through: both sections unity gain.
        wcoef(0, 0, 32768);
        wcoef(1, 0, 32768);
        send(16'h4000);
        recv(yv, lat);
        check("pass_latency", lat, 32'd13);
        check("pass_y", {16'b0, yv}, 32'h4000);
        check("pass_sat", {31'b0, sat_flag}, 32'd0);

        // Backpressure: output held, second sample waits.
        send(16'h2000);
        bus.x        = 16'h1000;
        bus.in_valid = 1'b1;
        lat = 0;
        while (!bus.out_valid && lat < 200) begin
            tick();
            lat++;
        end
        check("bp_valid", {31'b0, bus.out_valid}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            ys = bus.y;
            check("bp_y_stable", {16'b0, ys}, 32'h2000);
            check("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("bp_out_valid_drop", {31'b0, bus.out_valid}, 32'd0);
        check("bp_idle_ready", {31'b0, bus.in_ready}, 32'd1);
        tick();
        bus.in_valid = 1'b0;
        check("bp_accepted", {31'b0, bus.in_ready}, 32'd0);
        recv(yv, lat);
        check("bp_second_latency", lat, 32'd13);
        check("bp_second_y", {16'b0, yv}, 32'h1000);

        // Coefficient write during CALC is dropped.
        send(16'h4000);
        tick();
        tick();
        wcoef(0, 0, 0);
        recv(yv, lat);
        check("drop_y0", {16'b0, yv}, 32'h4000);
        send(16'h2000);
        recv(yv, lat);
        check("drop_y1", {16'b0, yv}, 32'h2000);

        // Single pole: w = u + 0.5*w1 in section 0, impulse response halves.
        pulse_clear();
        wcoef(0, 3, -16384);
        pole_exp = '{16'h4000, 16'h2000, 16'h1000, 16'h0800};
        for (int i = 0; i < 4; i++) begin
            send((i == 0) ? 16'h4000 : 16'h0000);
            recv(yv, lat);
            check($sformatf("pole_y%0d", i), {16'b0, yv}, {16'b0, pole_exp[i]});
        end

        // Saturation at the output conversion, both signs, then clear.
        wcoef(0, 3, 0);
        wcoef(0, 0, 62259);
        pulse_clear();
        send(16'h7FFF);
        recv(yv, lat);
        check("sat_pos_y", {16'b0, yv}, 32'h7FFF);
        check("sat_pos_flag", {31'b0, sat_flag}, 32'd1);
        send(16'h8000);
        recv(yv, lat);
        check("sat_neg_y", {16'b0, yv}, 32'h8000);
        pulse_clear();
        check("sat_cleared", {31'b0, sat_flag}, 32'd0);

        // Asynchronous reset in the middle of CALC.
        send(16'h4000);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        check("mid_rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("mid_rst_y", {16'b0, bus.y}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        send(16'h4000);
        recv(yv, lat);
        check("post_rst_latency", lat, 32'd13);
        check("post_rst_y", {16'b0, yv}, 32'd0);
        check("post_rst_sat", {31'b0, sat_flag}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
